// File: rtl/axi_mem_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to memory-port bridge.
//   - AXI response codes used on s_bresp / s_rresp
//   - bridge FSM state encoding (also visible on the bridge debug port)
package axi_mem_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RD_RESP = 3'd5
  } state_t;

endpackage

// File: rtl/axi_lite_mem_bridge.sv
// AXI4-Lite slave that turns single-beat reads/writes into transactions on
// the shared memory's request/grant port. One transaction in flight at a time.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   s_aw*/s_w*/s_b*                   AXI4-Lite write address/data/response
//   s_ar*/s_r*                        AXI4-Lite read address/data
//   mem_request, mem_we, mem_addr,
//   mem_wdata                         memory-port request (bridge is initiator)
//   mem_rdata                         read data, valid the cycle after a read request
//   mem_grant                         write grant from the memory
//   dbg_state                         current FSM state (axi_mem_bridge_pkg::state_t)
//
// Handshake rule for every AXI channel: a transfer happens on a rising clk edge
// where both valid and ready are high. The bridge holds each response valid and
// its payload stable until that edge; its readies are combinational and only
// ever high in IDLE.
module axi_lite_mem_bridge
  import axi_mem_bridge_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int WIDTH      = 32,
  parameter int AXI_ADDR_W = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [AXI_ADDR_W-1:0] s_awaddr,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [WIDTH-1:0]      s_wdata,
  input  logic [WIDTH/8-1:0]    s_wstrb,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [AXI_ADDR_W-1:0] s_araddr,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [WIDTH-1:0]      s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  mem_request,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_grant,
  output logic [2:0]            dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [WIDTH/8-1:0] STRB_ALL = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rr_wr_first_q, rr_wr_first_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic wr_pending, rd_pending, idle_ok, sel_wr, sel_rd;
  logic aw_out_of_range, ar_out_of_range;

  // Byte-offset bits carry no meaning for a word-wide memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

  // A write needs both AW and W so they are always taken together.
  // Readies are masked during reset so nothing is accepted that reset would drop.
  assign wr_pending = s_awvalid && s_wvalid;
  assign rd_pending = s_arvalid;
  assign idle_ok    = (state_q == IDLE) && rst_n;
  assign sel_wr     = idle_ok && wr_pending && (!rd_pending || rr_wr_first_q);
  assign sel_rd     = idle_ok && rd_pending && (!wr_pending || !rr_wr_first_q);

  assign s_awready = sel_wr;
  assign s_wready  = sel_wr;
  assign s_arready = sel_rd;

  // Any set bit above the memory's word-address range is a decode error.
  assign aw_out_of_range = (s_awaddr >> (ADDR_W + 2)) != '0;
  assign ar_out_of_range = (s_araddr >> (ADDR_W + 2)) != '0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_wr_first_d = rr_wr_first_q;
    bresp_d       = bresp_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    wdata_d       = wdata_q;
    addr_d        = addr_q;
    mem_request   = 1'b0;
    mem_we        = 1'b0;
    s_bvalid      = 1'b0;
    s_rvalid      = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_wr) begin
          // Whatever was served, the other type gets priority next time.
          rr_wr_first_d = 1'b0;
          if (aw_out_of_range) begin
            bresp_d = RESP_DECERR;
            state_d = WR_RESP;
          end else if (s_wstrb != STRB_ALL) begin
            // The memory has no byte enables, so partial writes are refused.
            bresp_d = RESP_SLVERR;
            state_d = WR_RESP;
          end else begin
            addr_d  = s_awaddr[ADDR_W+1:2];
            wdata_d = s_wdata;
            cnt_d   = '0;
            state_d = WR_REQ;
          end
        end else if (sel_rd) begin
          rr_wr_first_d = 1'b1;
          if (ar_out_of_range) begin
            rresp_d = RESP_DECERR;
            rdata_d = '0;
            state_d = RD_RESP;
          end else begin
            addr_d  = s_araddr[ADDR_W+1:2];
            state_d = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        mem_request = 1'b1;
        mem_we      = 1'b1;
        // A grant on the final wait cycle still wins over the timeout.
        if (mem_grant) begin
          bresp_d = RESP_OKAY;
          state_d = WR_RESP;
        end else if (cnt_q == CNT_LAST) begin
          bresp_d = RESP_SLVERR;
          state_d = WR_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WR_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) state_d = IDLE;
      end

      RD_REQ: begin
        // Reads are not granted; the memory answers on the following cycle.
        mem_request = 1'b1;
        state_d     = RD_DATA;
      end

      RD_DATA: begin
        rdata_d = mem_rdata;
        rresp_d = RESP_OKAY;
        state_d = RD_RESP;
      end

      RD_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rr_wr_first_q <= 1'b1;
      bresp_q       <= RESP_OKAY;
      rresp_q       <= RESP_OKAY;
      rdata_q       <= '0;
      wdata_q       <= '0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_wr_first_q <= rr_wr_first_d;
      bresp_q       <= bresp_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      wdata_q       <= wdata_d;
      addr_q        <= addr_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign s_bresp   = bresp_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
// Bench for axi_lite_mem_bridge: a memory-port model with a programmable grant
// delay, AXI driver tasks, and a reference model (array of words + response
// rules) that predicts responses, data and memory-port activity.
module tb_axi_lite_mem_bridge;
  import axi_mem_bridge_pkg::*;

  localparam int ADDR_W = 8;
  localparam int WIDTH = 32;
  localparam int AXI_ADDR_W = 12;
  localparam int TIMEOUT = 16;
  localparam int DEPTH = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
  logic s_arvalid = 1'b0, s_rready = 1'b0;
  logic [AXI_ADDR_W-1:0] s_awaddr = '0, s_araddr = '0;
  logic [WIDTH-1:0] s_wdata = '0;
  logic [WIDTH/8-1:0] s_wstrb = '0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [WIDTH-1:0] s_rdata;
  logic mem_request, mem_we, mem_grant;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic [2:0] dbg_state;

  axi_lite_mem_bridge #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .AXI_ADDR_W(AXI_ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .mem_request(mem_request), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_grant(mem_grant),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // ---------------- memory-port model ----------------
  // grant_delay = number of request cycles before grant (-1: never grant).
  int grant_delay = 1;
  int req_age = 0;
  logic [WIDTH-1:0] mem_arr [0:DEPTH-1] = '{default: '0};

  assign mem_grant = mem_request && mem_we && (grant_delay >= 0) && (req_age == grant_delay);

  always @(posedge clk) begin
    if (mem_request && mem_we) begin
      req_age <= req_age + 1;
      if (mem_grant) mem_arr[mem_addr] <= mem_wdata;
    end else begin
      req_age <= 0;
    end
    if (mem_request && !mem_we) mem_rdata <= mem_arr[mem_addr];
  end

  // Monitor of memory-port activity, counted per cycle.
  int wr_req_cyc = 0, rd_req_cyc = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [WIDTH-1:0] last_wr_data = '0;
  always @(negedge clk) begin
    if (mem_request && mem_we) begin
      wr_req_cyc <= wr_req_cyc + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
    end
    if (mem_request && !mem_we) begin
      rd_req_cyc <= rd_req_cyc + 1;
      last_rd_addr <= mem_addr;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [WIDTH-1:0] ref_mem [0:DEPTH-1] = '{default: '0};
  logic [WIDTH-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit in_range(input logic [AXI_ADDR_W-1:0] a);
    return int'(a) < (4 * DEPTH);
  endfunction

  function automatic logic [1:0] ref_wr_resp(input logic [AXI_ADDR_W-1:0] a, input logic [3:0] strb, input int gd);
    if (!in_range(a)) return RESP_DECERR;
    if (strb != 4'hF) return RESP_SLVERR;
    if (gd < 0 || gd >= TIMEOUT) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Cycles of write request the memory port should see, and edges from the
  // AW/W handshake until bvalid is visible.
  function automatic int ref_wr_req_cycles(input logic [1:0] resp, input bit accessed, input int gd);
    if (!accessed) return 0;
    return (resp == RESP_OKAY) ? gd + 1 : TIMEOUT;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic [AXI_ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                             input logic [3:0] strb, input int hold,
                             output logic [1:0] resp, output int lat, output bit stable, output bit ok);
    int n;
    ok = 1'b1; stable = 1'b1; resp = 2'b00; lat = 0; n = 0;
    @(posedge clk); #1;
    s_awaddr = a; s_wdata = d; s_wstrb = strb; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    while (!(s_awready && s_wready) && n < 50) begin @(negedge clk); n++; end
    if (!(s_awready && s_wready)) ok = 1'b0;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (!ok) return;
    @(negedge clk);
    while (!s_bvalid && lat < 100) begin lat++; @(negedge clk); end
    if (!s_bvalid) begin ok = 1'b0; return; end
    resp = s_bresp;
    repeat (hold) begin
      @(negedge clk);
      if (!s_bvalid || s_bresp !== resp) stable = 1'b0;
    end
    @(posedge clk); #1 s_bready = 1'b1;
    @(posedge clk); #1 s_bready = 1'b0;
  endtask

  task automatic drive_read(input logic [AXI_ADDR_W-1:0] a, input int hold,
                            output logic [WIDTH-1:0] d, output logic [1:0] resp,
                            output int lat, output bit stable, output bit ok);
    int n;
    ok = 1'b1; stable = 1'b1; resp = 2'b00; d = '0; lat = 0; n = 0;
    @(posedge clk); #1;
    s_araddr = a; s_arvalid = 1'b1;
    @(negedge clk);
    while (!s_arready && n < 50) begin @(negedge clk); n++; end
    if (!s_arready) ok = 1'b0;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    if (!ok) return;
    @(negedge clk);
    while (!s_rvalid && lat < 100) begin lat++; @(negedge clk); end
    if (!s_rvalid) begin ok = 1'b0; return; end
    resp = s_rresp; d = s_rdata;
    repeat (hold) begin
      @(negedge clk);
      if (!s_rvalid || s_rresp !== resp || s_rdata !== d) stable = 1'b0;
    end
    @(posedge clk); #1 s_rready = 1'b1;
    @(posedge clk); #1 s_rready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Requests offered during reset must not be acknowledged.
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_wstrb = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, mem_request, mem_we} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 0", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, mem_request, mem_we});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, s_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_data: addr %h wdata %h rdata %h expected 0", mem_addr, mem_wdata, s_rdata);
    end
    n_cmp++;
    if ({s_bresp, s_rresp} !== 4'b0) begin
      n_bad++; $display("FAIL reset_resp: got %b expected 0", {s_bresp, s_rresp});
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_write_basic();
    logic [1:0] resp; int lat, w0, r0; bit stable, ok;
    grant_delay = 1; w0 = wr_req_cyc; r0 = rd_req_cyc;
    drive_write(12'h010, 32'hDEADBEEF, 4'hF, 2, resp, lat, stable, ok);
    ref_mem[4] = 32'hDEADBEEF;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_basic_done: got %0d expected 1", ok); end
    n_cmp++; if (last_wr_addr !== 8'd4) begin n_bad++; $display("FAIL wr_basic_addr: got %h expected 04", last_wr_addr); end
    n_cmp++; if (last_wr_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_basic_wdata: got %h expected deadbeef", last_wr_data); end
    n_cmp++; if ((wr_req_cyc - w0) != 2 || (rd_req_cyc - r0) != 0) begin
      n_bad++; $display("FAIL wr_basic_req: got we=1 %0d / we=0 %0d cycles expected 2 / 0", wr_req_cyc - w0, rd_req_cyc - r0);
    end
    n_cmp++; if (resp !== RESP_OKAY) begin n_bad++; $display("FAIL wr_basic_bresp: got %b expected %b", resp, RESP_OKAY); end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL wr_basic_latency: got %0d expected 2", lat); end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL wr_basic_stable: got %0d expected 1", stable); end
  endtask

  task automatic test_read_basic();
    logic [WIDTH-1:0] d, e; logic [1:0] resp; int lat, w0, r0; bit stable, ok;
    w0 = wr_req_cyc; r0 = rd_req_cyc;
    exp_q.push_back(ref_mem[4]);
    drive_read(12'h010, 2, d, resp, lat, stable, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rd_basic_done: got %0d expected 1", ok); end
    n_cmp++; if ((rd_req_cyc - r0) != 1 || (wr_req_cyc - w0) != 0) begin
      n_bad++; $display("FAIL rd_basic_req: got we=0 %0d / we=1 %0d cycles expected 1 / 0", rd_req_cyc - r0, wr_req_cyc - w0);
    end
    n_cmp++; if (last_rd_addr !== 8'd4) begin n_bad++; $display("FAIL rd_basic_addr: got %h expected 04", last_rd_addr); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL rd_basic_rdata: got %h expected %h", d, e); end
    n_cmp++; if (resp !== RESP_OKAY) begin n_bad++; $display("FAIL rd_basic_rresp: got %b expected %b", resp, RESP_OKAY); end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL rd_basic_latency: got %0d expected 2", lat); end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL rd_basic_stable: got %0d expected 1", stable); end
  endtask

  task automatic test_timeout();
    logic [1:0] resp; int lat, w0; bit stable, ok; logic [WIDTH-1:0] d;
    grant_delay = -1; w0 = wr_req_cyc; d = $urandom;
    drive_write(12'h0C8, d, 4'hF, 0, resp, lat, stable, ok);
    n_cmp++; if ((wr_req_cyc - w0) != TIMEOUT) begin n_bad++; $display("FAIL timeout_req: got %0d cycles expected %0d", wr_req_cyc - w0, TIMEOUT); end
    n_cmp++; if (resp !== RESP_SLVERR || !ok) begin n_bad++; $display("FAIL timeout_bresp: got %b expected %b", resp, RESP_SLVERR); end
    grant_delay = 9; w0 = wr_req_cyc;
    drive_write(12'h0C8, d, 4'hF, 0, resp, lat, stable, ok);
    ref_mem[8'h32] = d;
    n_cmp++; if ((wr_req_cyc - w0) != 10) begin n_bad++; $display("FAIL late_grant_req: got %0d cycles expected 10", wr_req_cyc - w0); end
    n_cmp++; if (resp !== RESP_OKAY || !ok) begin n_bad++; $display("FAIL late_grant_bresp: got %b expected %b", resp, RESP_OKAY); end
    n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL late_grant_latency: got %0d expected 10", lat); end
  endtask

  task automatic test_errors();
    logic [WIDTH-1:0] d; logic [1:0] resp; int lat, w0, r0; bit stable, ok;
    grant_delay = 1;
    w0 = wr_req_cyc; r0 = rd_req_cyc;
    drive_write(12'h400, 32'h12345678, 4'hF, 0, resp, lat, stable, ok);
    n_cmp++; if (resp !== RESP_DECERR || !ok) begin n_bad++; $display("FAIL aw_decerr: got %b expected %b", resp, RESP_DECERR); end
    drive_write(12'h010, 32'h12345678, 4'h3, 0, resp, lat, stable, ok);
    n_cmp++; if (resp !== RESP_SLVERR || !ok) begin n_bad++; $display("FAIL strb_slverr: got %b expected %b", resp, RESP_SLVERR); end
    drive_read(12'h800, 0, d, resp, lat, stable, ok);
    n_cmp++; if (resp !== RESP_DECERR || !ok) begin n_bad++; $display("FAIL ar_decerr: got %b expected %b", resp, RESP_DECERR); end
    n_cmp++; if (d !== '0) begin n_bad++; $display("FAIL ar_decerr_rdata: got %h expected 0", d); end
    n_cmp++; if ((wr_req_cyc - w0) + (rd_req_cyc - r0) != 0) begin
      n_bad++; $display("FAIL err_no_access: got %0d request cycles expected 0", (wr_req_cyc - w0) + (rd_req_cyc - r0));
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d, d0, e; logic [AXI_ADDR_W-1:0] a; logic [1:0] r0;
    bit exp_wr, got_wr, stable; int n;
    pulse_reset();
    grant_delay = 1;
    d = $urandom;
    a = {2'b00, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
    s_awaddr = a; s_wdata = d; s_wstrb = 4'hF; s_araddr = a;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_wr = (k % 2 == 0);
      if (exp_wr) ref_mem[a[ADDR_W+1:2]] = d;
      else exp_q.push_back(ref_mem[a[ADDR_W+1:2]]);
      n = 0;
      @(negedge clk);
      while (!s_bvalid && !s_rvalid && n < 100) begin @(negedge clk); n++; end
      got_wr = s_bvalid;
      n_cmp++; if (!(s_bvalid || s_rvalid)) begin n_bad++; $display("FAIL b2b_timeout_%0d: got no response expected one", k); end
      n_cmp++; if (got_wr != exp_wr) begin n_bad++; $display("FAIL b2b_order_%0d: got write=%0d expected write=%0d", k, got_wr, exp_wr); end
      r0 = got_wr ? s_bresp : s_rresp;
      d0 = s_rdata;
      n_cmp++; if (r0 !== RESP_OKAY) begin n_bad++; $display("FAIL b2b_resp_%0d: got %b expected %b", k, r0, RESP_OKAY); end
      if (!exp_wr) begin
        e = exp_q.pop_front();
        n_cmp++; if (d0 !== e) begin n_bad++; $display("FAIL b2b_rdata_%0d: got %h expected %h", k, d0, e); end
      end
      stable = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (got_wr ? (!s_bvalid || s_bresp !== r0) : (!s_rvalid || s_rresp !== r0 || s_rdata !== d0)) stable = 1'b0;
      end
      n_cmp++; if (!stable) begin n_bad++; $display("FAIL b2b_stable_%0d: got %0d expected 1", k, stable); end
      @(posedge clk); #1;
      if (got_wr) s_bready = 1'b1; else s_rready = 1'b1;
      if (k == 3) begin s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; end
      @(posedge clk); #1;
      s_bready = 1'b0; s_rready = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d, e; logic [AXI_ADDR_W-1:0] a; logic [3:0] strb; logic [1:0] resp, er;
    int lat, gd, w0, r0, el, ec; bit stable, ok, is_wr;
    for (int i = 0; i < 24; i++) begin
      is_wr = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) a = 12'h400 | 12'($urandom_range(0, 12'hBFF));
      else a = {2'b00, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
      w0 = wr_req_cyc; r0 = rd_req_cyc;
      if (is_wr) begin
        strb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        gd = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 12);
        grant_delay = gd;
        d = $urandom;
        er = ref_wr_resp(a, strb, gd);
        ec = ref_wr_req_cycles(er, in_range(a) && strb == 4'hF, gd);
        el = (ec == 0) ? 0 : ec;
        drive_write(a, d, strb, $urandom_range(0, 2), resp, lat, stable, ok);
        if (er == RESP_OKAY) ref_mem[a[ADDR_W+1:2]] = d;
        n_cmp++; if (!ok || resp !== er || lat != el) begin
          n_bad++; $display("FAIL rand_wr_%0d: addr %h strb %h gd %0d got resp %b lat %0d expected resp %b lat %0d", i, a, strb, gd, resp, lat, er, el);
        end
        n_cmp++; if ((wr_req_cyc - w0) != ec || !stable) begin
          n_bad++; $display("FAIL rand_wr_req_%0d: got %0d cycles stable %0d expected %0d cycles stable 1", i, wr_req_cyc - w0, stable, ec);
        end
      end else begin
        grant_delay = 1;
        exp_q.push_back(in_range(a) ? ref_mem[a[ADDR_W+1:2]] : '0);
        er = in_range(a) ? RESP_OKAY : RESP_DECERR;
        el = in_range(a) ? 2 : 0;
        drive_read(a, $urandom_range(0, 2), d, resp, lat, stable, ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || resp !== er || d !== e || lat != el || !stable) begin
          n_bad++; $display("FAIL rand_rd_%0d: addr %h got resp %b data %h lat %0d expected resp %b data %h lat %0d", i, a, resp, d, lat, er, e, el);
        end
        n_cmp++; if ((rd_req_cyc - r0) != (in_range(a) ? 1 : 0)) begin
          n_bad++; $display("FAIL rand_rd_req_%0d: got %0d cycles expected %0d", i, rd_req_cyc - r0, in_range(a) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] d, e; logic [1:0] resp; int lat; bit stable, ok;
    grant_delay = -1;
    @(posedge clk); #1;
    s_awaddr = 12'h044; s_wdata = $urandom; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    n_cmp++; if (s_awready !== 1'b1) begin n_bad++; $display("FAIL mid_accept: got %b expected 1", s_awready); end
    @(posedge clk); #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_request !== 1'b1 || dbg_state !== WR_REQ) begin
      n_bad++; $display("FAIL mid_in_wr_req: got req %b state %0d expected 1 %0d", mem_request, dbg_state, WR_REQ);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_request !== 1'b0 || {s_bvalid, s_rvalid} !== 2'b00 || dbg_state !== IDLE) begin
      n_bad++; $display("FAIL mid_after_reset: got req %b valids %b state %0d expected 0 00 %0d", mem_request, {s_bvalid, s_rvalid}, dbg_state, IDLE);
    end
    grant_delay = 1;
    exp_q.push_back(ref_mem[4]);
    drive_read(12'h010, 0, d, resp, lat, stable, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || d !== e || resp !== RESP_OKAY || lat != 2) begin
      n_bad++; $display("FAIL mid_read_after: got data %h resp %b lat %0d expected %h %b 2", d, resp, lat, e, RESP_OKAY);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_timeout();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched so far", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
